// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - spart bus master: baud divisor setup, status polling, receive-and-echo FIFO
// Optional ECHO_UPPER_EN: lowercase ASCII is folded to uppercase as bytes enter the echo FIFO.
module spart_driver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  input  logic                          rda,
  input  logic                          tbr,
  output logic                          rx_valid,
  output logic [7:0]                    rx_byte,
  output logic                          cfg_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / 4800 - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / 9600 - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / 19200 - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / 38400 - 1);

  typedef enum logic [2:0] {
    S_DIV_LO, S_DIV_HI, S_POLL, S_DECIDE, S_RD_DATA, S_WR_DATA, S_GAP
  } state_t;

  state_t          state, next;
  logic [1:0]      cfg_latched;
  logic [1:0]      status;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [GW-1:0]   gap_cnt;
  logic            full, empty;
  logic [15:0]     div_new, div_cur;
  logic [7:0]      push_byte;
  logic            bus_cs, bus_rw;
  logic [1:0]      bus_addr;
  logic [7:0]      bus_wdata;

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   divisor = DIV_4800;
      2'b01:   divisor = DIV_9600;
      2'b10:   divisor = DIV_19200;
      default: divisor = DIV_38400;
    endcase
  endfunction

  assign div_new  = divisor(br_cfg);
  assign div_cur  = divisor(cfg_latched);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign fifo_cnt = count;

`ifdef ECHO_UPPER_EN
  assign push_byte = (databus >= 8'h61 && databus <= 8'h7A) ? (databus - 8'h20) : databus;
`else
  assign push_byte = databus;
`endif

  always_comb begin
    next      = state;
    bus_cs    = 1'b0;
    bus_rw    = 1'b1;
    bus_addr  = 2'b00;
    bus_wdata = 8'h00;
    case (state)
      S_DIV_LO: begin
        bus_cs    = 1'b1;
        bus_rw    = 1'b0;
        bus_addr  = 2'b10;
        bus_wdata = div_new[7:0];
        next      = S_DIV_HI;
      end
      S_DIV_HI: begin
        bus_cs    = 1'b1;
        bus_rw    = 1'b0;
        bus_addr  = 2'b11;
        bus_wdata = div_cur[15:8];
        next      = S_POLL;
      end
      S_POLL: begin
        bus_cs   = 1'b1;
        bus_addr = 2'b01;
        next     = S_DECIDE;
      end
      // Receive outranks transmit so the spart is drained before it can overrun.
      S_DECIDE: begin
        if (br_cfg != cfg_latched)  next = S_DIV_LO;
        else if (status[0] && !full) next = S_RD_DATA;
        else if (status[1] && !empty) next = S_WR_DATA;
        else                          next = S_POLL;
      end
      S_RD_DATA: begin
        bus_cs = 1'b1;
        next   = S_POLL;
      end
      S_WR_DATA: begin
        bus_cs    = 1'b1;
        bus_rw    = 1'b0;
        bus_wdata = mem[rd_ptr];
        next      = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) next = S_POLL;
      end
      default: next = S_DIV_LO;
    endcase
  end

  // Reset gates the strobe directly so the bus is released without waiting for a clock.
  assign iocs    = bus_cs & ~rst;
  assign iorw    = bus_rw | rst;
  assign ioaddr  = rst ? 2'b00 : bus_addr;
  assign databus = (iocs && !iorw) ? bus_wdata : 8'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_DIV_LO;
    else     state <= next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_latched <= 2'b00;
      cfg_done    <= 1'b0;
      status      <= 2'b00;
      rx_valid    <= 1'b0;
      rx_byte     <= 8'h00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      gap_cnt     <= '0;
    end else begin
      rx_valid <= (state == S_RD_DATA);
      case (state)
        S_DIV_LO: cfg_latched <= br_cfg;
        S_DIV_HI: cfg_done <= 1'b1;
        S_POLL:   status <= databus[1:0] & {tbr, rda};
        S_DECIDE: if (br_cfg != cfg_latched) cfg_done <= 1'b0;
        S_RD_DATA: begin
          rx_byte <= databus;
          wr_ptr  <= wr_ptr + 1'b1;
          count   <= count + 1'b1;
        end
        S_WR_DATA: begin
          rd_ptr  <= rd_ptr + 1'b1;
          count   <= count - 1'b1;
          gap_cnt <= '0;
        end
        S_GAP:    gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RD_DATA) mem[wr_ptr] <= push_byte;
  end

endmodule

// File: tb/tb_spart_driver.sv
// tb/tb_spart_driver.sv - randomized bench for spart_driver against a transaction-level echo model
module tb_spart_driver;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYC    = 2;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] K_WR = 3'b000, K_RD = 3'b100, K_POLL = 3'b101,
                         K_DLO = 3'b010, K_DHI = 3'b011;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    br_cfg = 2'b01;
  logic          rda = 1'b0;
  logic          tbr = 1'b0;
  logic          iocs, iorw;
  logic [1:0]    ioaddr;
  wire  [7:0]    databus;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          cfg_done;
  logic [CW-1:0] fifo_cnt;
  logic [7:0]    sp_head = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Spart side of the bus: answers status and data reads.
  assign databus = (iocs && iorw) ? ((ioaddr == 2'b01) ? {6'b0, tbr, rda} : sp_head) : 8'bz;

  spart_driver #(.CLK_HZ(50_000_000), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cfg_done(cfg_done), .fifo_cnt(fifo_cnt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    return 16'(50_000_000 / (4800 << sel) - 1);
  endfunction

  function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef ECHO_UPPER_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
`endif
    return b;
  endfunction

  // Transaction-level model: FIFO contents, next allowed access, spacing and flags.
  logic [7:0] mq[$];
  logic [7:0] echo_log[$];
  logic [7:0] div_log[$];
  logic [7:0] sp_q[$];
  int         rd_seen = 0;
  int         rd_done = 0;
  int         idle, idle_exp;
  logic [2:0] exp_kind, kind;
  logic       cfg_exp, rxv_exp, dec_pending;
  logic [7:0] rx_exp, head;
  logic [1:0] st, cfg_lat;
  logic [15:0] dv;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      exp_kind = K_DLO; idle = 0; idle_exp = 0;
      cfg_exp = 1'b0; rxv_exp = 1'b0; dec_pending = 1'b0;
    end else begin
      chk("fifo_cnt", 16'(fifo_cnt), 16'(mq.size()));
      chk("rx_valid", 16'(rx_valid), 16'(rxv_exp));
      if (rxv_exp) chk("rx_byte", 16'(rx_byte), 16'(rx_exp));
      chk("cfg_done", 16'(cfg_done), 16'(cfg_exp));
      rxv_exp = 1'b0;
      if (dec_pending) begin
        dec_pending = 1'b0;
        if (br_cfg != cfg_lat) begin exp_kind = K_DLO; cfg_exp = 1'b0; end
        else if (st[0] && mq.size() < FIFO_DEPTH) exp_kind = K_RD;
        else if (st[1] && mq.size() > 0) exp_kind = K_WR;
        else exp_kind = K_POLL;
      end
      if (iocs) begin
        kind = {iorw, ioaddr};
        chk("access_spacing", 16'(idle), 16'(idle_exp));
        chk("access_kind", 16'(kind), 16'(exp_kind));
        idle = 0; idle_exp = 0; exp_kind = K_POLL;
        case (kind)
          K_DLO: begin
            dv = div_of(br_cfg);
            chk("div_lo", 16'(databus), 16'(dv[7:0]));
            cfg_lat = br_cfg;
            div_log.push_back(databus);
            exp_kind = K_DHI;
          end
          K_DHI: begin
            dv = div_of(cfg_lat);
            chk("div_hi", 16'(databus), 16'(dv[15:8]));
            div_log.push_back(databus);
            cfg_exp = 1'b1;
          end
          K_POLL: begin
            st = {tbr, rda};
            dec_pending = 1'b1;
            idle_exp = 1;
          end
          K_RD: begin
            rx_exp = databus;
            rxv_exp = 1'b1;
            mq.push_back(echo_of(databus));
            rd_seen++;
          end
          K_WR: begin
            chk("wr_nonempty", 16'(mq.size() != 0), 16'd1);
            if (mq.size() != 0) begin
              head = mq.pop_front();
              chk("echo_data", 16'(databus), 16'(head));
            end
            echo_log.push_back(databus);
            idle_exp = GAP_CYC;
          end
          default: ;
        endcase
      end else begin
        idle++;
      end
    end
  end

  // One clock of spart behaviour: consume bytes the driver has read, refresh rda/head.
  task automatic step();
    logic [7:0] tmp;
    @(posedge clk);
    #1;
    while (rd_done < rd_seen) begin
      if (sp_q.size() != 0) tmp = sp_q.pop_front();
      rd_done++;
    end
    rda = (sp_q.size() != 0);
    if (sp_q.size() != 0) sp_head = sp_q[0];
  endtask

  task automatic sp_push(input logic [7:0] b);
    sp_q.push_back(b);
    rda = 1'b1;
    sp_head = sp_q[0];
  endtask

  task automatic wait_echo(input int n, input int budget);
    for (int i = 0; i < budget && echo_log.size() < n; i++) step();
    chk("echo_timeout", 16'(echo_log.size() >= n), 16'd1);
  endtask

  task automatic wait_fifo(input int n);
    for (int i = 0; i < 100 && int'(fifo_cnt) != n; i++) step();
    chk("fifo_fill", 16'(fifo_cnt), 16'(n));
  endtask

  initial begin
    int  base_e, base_d, base_r;
    bit  found;
    logic [7:0] exp_a;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iocs", 16'(iocs), 16'd0);
    chk("rst_iorw", 16'(iorw), 16'd1);
    chk("rst_ioaddr", 16'(ioaddr), 16'd0);
    chk("rst_rx_valid", 16'(rx_valid), 16'd0);
    chk("rst_rx_byte", 16'(rx_byte), 16'd0);
    chk("rst_cfg_done", 16'(cfg_done), 16'd0);
    chk("rst_fifo_cnt", 16'(fifo_cnt), 16'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Divisor programming for 9600 baud at 50 MHz.
    @(negedge clk);
    chk("t1_acc1_addr", 16'({iocs, iorw, ioaddr}), 16'b1010);
    chk("t1_acc1_data", 16'(databus), 16'h57);
    step(); @(negedge clk);
    chk("t1_acc2_addr", 16'({iocs, iorw, ioaddr}), 16'b1011);
    chk("t1_acc2_data", 16'(databus), 16'h14);
    chk("t1_cfg_early", 16'(cfg_done), 16'd0);
    step(); @(negedge clk);
    chk("t1_cfg_done", 16'(cfg_done), 16'd1);
    step();

    // Single byte echo.
    tbr = 1'b1;
    base_e = echo_log.size();
    sp_push(8'h41);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rx_valid) found = 1'b1;
      step();
    end
    chk("t2_rx_pulse", 16'(found), 16'd1);
    chk("t2_rx_byte", 16'(rx_byte), 16'h41);
    wait_echo(base_e + 1, 40);
    if (echo_log.size() > base_e) chk("t2_echo", 16'(echo_log[base_e]), 16'h41);

    // FIFO fills while the transmitter is busy, then drains in order.
    tbr = 1'b0;
    step();
    base_e = echo_log.size();
    base_r = rd_seen;
    for (int k = 0; k < 8; k++) sp_push(8'h30 + 8'(k));
    repeat (60) step();
    chk("t3_fifo_full", 16'(fifo_cnt), 16'd4);
    chk("t3_reads", 16'(rd_seen - base_r), 16'd4);
    chk("t3_left_in_spart", 16'(sp_q.size()), 16'd4);
    tbr = 1'b1;
    wait_echo(base_e + 8, 400);
    for (int k = 0; k < 8; k++)
      if (echo_log.size() > base_e + k)
        chk("t3_order", 16'(echo_log[base_e + k]), 16'(8'h30 + 8'(k)));

    // Baud change with data pending in the FIFO.
    tbr = 1'b0;
    step();
    sp_push(8'h50);
    sp_push(8'h51);
    wait_fifo(2);
    base_d = div_log.size();
    base_e = echo_log.size();
    br_cfg = 2'b11;
    for (int i = 0; i < 50 && div_log.size() < base_d + 2; i++) step();
    chk("t4_div_count", 16'(div_log.size() - base_d), 16'd2);
    if (div_log.size() >= base_d + 2) begin
      chk("t4_div_lo", 16'(div_log[base_d]), 16'h15);
      chk("t4_div_hi", 16'(div_log[base_d + 1]), 16'h05);
    end
    step();
    chk("t4_fifo_kept", 16'(fifo_cnt), 16'd2);
    chk("t4_cfg_done", 16'(cfg_done), 16'd1);
    tbr = 1'b1;
    wait_echo(base_e + 2, 60);
    if (echo_log.size() >= base_e + 2) begin
      chk("t4_echo0", 16'(echo_log[base_e]), 16'h50);
      chk("t4_echo1", 16'(echo_log[base_e + 1]), 16'h51);
    end

    // Case folding.
    base_e = echo_log.size();
    sp_push(8'h61);
    sp_push(8'h7B);
    wait_echo(base_e + 2, 80);
`ifdef ECHO_UPPER_EN
    exp_a = 8'h41;
`else
    exp_a = 8'h61;
`endif
    if (echo_log.size() >= base_e + 2) begin
      chk("t6_echo_a", 16'(echo_log[base_e]), 16'(exp_a));
      chk("t6_echo_brace", 16'(echo_log[base_e + 1]), 16'h7B);
    end

    // Reset in the middle of a data write.
    tbr = 1'b0;
    step();
    sp_push(8'h44);
    wait_fifo(1);
    tbr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (iocs && !iorw && ioaddr == 2'b00) found = 1'b1;
      else step();
    end
    chk("t5_found_write", 16'(found), 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_iocs_drop", 16'(iocs), 16'd0);
    chk("t5_bus_release", 16'(iorw), 16'd1);
    chk("t5_fifo_clear", 16'(fifo_cnt), 16'd0);
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_restart_addr", 16'({iocs, iorw, ioaddr}), 16'b1010);
    chk("t5_restart_data", 16'(databus), 16'h15);
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0 && sp_q.size() < 6) sp_push(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) tbr = ~tbr;
      if ($urandom_range(0, 499) == 0) br_cfg = 2'($urandom_range(0, 3));
      step();
    end
    tbr = 1'b1;
    for (int i = 0; i < 600 && (sp_q.size() != 0 || fifo_cnt != '0); i++) step();
    repeat (10) step();
    chk("drain_spart", 16'(sp_q.size()), 16'd0);
    chk("drain_fifo", 16'(fifo_cnt), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
